// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, derived totals, sync windows and colour helpers.
// The colour-bar test pattern is compiled in only with VGA_SCAN_TESTPAT_EN.
package vga_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned PIX_DIV_DEF  = 4;
    localparam int unsigned RGB_LAT_DEF  = 1;

    localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned HS_FIRST_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int unsigned HS_LAST_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF - 1;
    localparam int unsigned VS_FIRST_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int unsigned VS_LAST_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF - 1;

    typedef logic [11:0] rgb12_t;

    localparam rgb12_t BAR_WHITE   = 12'hFFF;
    localparam rgb12_t BAR_YELLOW  = 12'hFF0;
    localparam rgb12_t BAR_CYAN    = 12'h0FF;
    localparam rgb12_t BAR_GREEN   = 12'h0F0;
    localparam rgb12_t BAR_MAGENTA = 12'hF0F;
    localparam rgb12_t BAR_RED     = 12'hF00;
    localparam rgb12_t BAR_BLUE    = 12'h00F;
    localparam rgb12_t BAR_BLACK   = 12'h000;

    function automatic rgb12_t bar_colour(input logic [2:0] idx);
        rgb12_t c;
        unique case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Pixel-clock divider with horizontal/vertical scan counters.
// wrap flags the pix_tick that takes both counters back to (0,0).
module scan_counter import vga_pkg::*; #(
    parameter int unsigned H_TOTAL = H_TOTAL_DEF,
    parameter int unsigned V_TOTAL = V_TOTAL_DEF,
    parameter int unsigned PIX_DIV = PIX_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             pix_tick,
    output logic             wrap
);

    localparam int unsigned      DIV_W    = $clog2(PIX_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] div;
    logic             col_wrap;

    assign pix_tick = (div == DIV_LAST);
    assign col_wrap = pix_tick && (col == COL_LAST);
    assign wrap     = col_wrap && (row == ROW_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            col <= '0;
            row <= '0;
        end else begin
            div <= pix_tick ? '0 : div + DIV_W'(1);
            if (pix_tick) begin
                col <= col_wrap ? '0 : col + CNT_W'(1);
                if (col_wrap) begin
                    row <= (row == ROW_LAST) ? '0 : row + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/vga_scan.sv
// Raster scan controller: scan coordinates out, registered hs/vs/rgb one pixel later.
// Define VGA_SCAN_TESTPAT_EN to build the test_sel colour-bar generator.
module vga_scan import vga_pkg::*; #(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned PIX_DIV  = PIX_DIV_DEF,
    parameter int unsigned RGB_LAT  = RGB_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      rgb_in,
    input  logic             test_sel,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             pix_tick,
    output logic             frame_start,
    output logic             hs,
    output logic             vs,
    output logic [11:0]      rgb
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // rgb_in is sampled on pix_tick, PIX_DIV-1 clks after each coordinate change,
    // which is what makes any RGB_LAT < PIX_DIV safe without a handshake.
    localparam int unsigned unused_rgb_lat = RGB_LAT;

    logic   wrap;
    logic   h_sync_on;
    logic   v_sync_on;
    logic   active;
    rgb12_t src;

    scan_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .PIX_DIV (PIX_DIV)
    ) u_scan_counter (
        .clk      (clk),
        .rst      (rst),
        .col      (col),
        .row      (row),
        .pix_tick (pix_tick),
        .wrap     (wrap)
    );

`ifdef VGA_SCAN_TESTPAT_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    rgb12_t bar;

    // Descending compare chain: the lowest matching boundary wins.
    always_comb begin
        bar = bar_colour(3'd7);
        for (int i = 6; i >= 0; i--) begin
            if (col < CNT_W'(BAR_W * (i + 1))) begin
                bar = bar_colour(3'(i));
            end
        end
    end

    assign src = test_sel ? bar : rgb_in;
`else
    logic unused_test_sel;
    assign unused_test_sel = test_sel;
    assign src = rgb_in;
`endif

    assign h_sync_on = (col >= HS_FIRST) && (col <= HS_LAST);
    assign v_sync_on = (row >= VS_FIRST) && (row <= VS_LAST);
    assign active    = (col < H_VIS) && (row < V_VIS);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start <= 1'b0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            rgb         <= '0;
        end else begin
            frame_start <= wrap;
            if (pix_tick) begin
                hs  <= ~h_sync_on;
                vs  <= ~v_sync_on;
                rgb <= active ? src : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan.sv
// Self-checking bench for vga_scan with a scaled-down raster and a per-clock
// arithmetic reference model derived from the clock count since reset.
module tb_vga_scan;

    localparam int unsigned H_ACTIVE = 16;
    localparam int unsigned H_FP     = 2;
    localparam int unsigned H_SYNC   = 3;
    localparam int unsigned H_BP     = 3;
    localparam int unsigned V_ACTIVE = 8;
    localparam int unsigned V_FP     = 2;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 2;
    localparam int unsigned PIX_DIV  = 4;
    localparam int unsigned RGB_LAT  = 1;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned FRAME    = H_TOTAL * V_TOTAL * PIX_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] rgb_in;
    logic        test_sel;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        pix_tick;
    logic        frame_start;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned k        = 0;
    int unsigned abs_cyc  = 0;
    int unsigned last_fs  = 0;
    int unsigned n_fs     = 0;
    logic [11:0] held     = '0;

`ifdef VGA_SCAN_TESTPAT_EN
    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};
`endif

    always #5 clk = ~clk;

    vga_scan #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .PIX_DIV  (PIX_DIV),
        .RGB_LAT  (RGB_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rgb_in      (rgb_in),
        .test_sel    (test_sel),
        .col         (col),
        .row         (row),
        .pix_tick    (pix_tick),
        .frame_start (frame_start),
        .hs          (hs),
        .vs          (vs),
        .rgb         (rgb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    // Colour the renderer path should deliver for column c right now.
    function automatic logic [11:0] source_colour(input int unsigned c);
`ifdef VGA_SCAN_TESTPAT_EN
        if (test_sel) return (c < H_ACTIVE) ? bars[c / (H_ACTIVE / 8)] : 12'h000;
`endif
        return rgb_in;
    endfunction

    task automatic model_check();
        int unsigned p, ph, c, r, q, qc, qr;
        logic        e_hs, e_vs;
        logic [11:0] e_rgb;
        p  = k / PIX_DIV;
        ph = k % PIX_DIV;
        c  = p % H_TOTAL;
        r  = (p / H_TOTAL) % V_TOTAL;
        check("col", 32'(col), c);
        check("row", 32'(row), r);
        check("pix_tick", 32'(pix_tick), 32'(ph == PIX_DIV - 1));
        check("frame_start", 32'(frame_start), 32'(k != 0 && k % FRAME == 0));
        if (p == 0) begin
            e_hs  = 1'b1;
            e_vs  = 1'b1;
            e_rgb = 12'h000;
        end else begin
            q     = p - 1;
            qc    = q % H_TOTAL;
            qr    = (q / H_TOTAL) % V_TOTAL;
            e_hs  = !(qc >= H_ACTIVE + H_FP && qc < H_ACTIVE + H_FP + H_SYNC);
            e_vs  = !(qr >= V_ACTIVE + V_FP && qr < V_ACTIVE + V_FP + V_SYNC);
            e_rgb = (qc < H_ACTIVE && qr < V_ACTIVE) ? held : 12'h000;
        end
        check("hs", 32'(hs), 32'(e_hs));
        check("vs", 32'(vs), 32'(e_vs));
        check("rgb", 32'(rgb), 32'(e_rgb));
        if (frame_start === 1'b1) begin
            check("fs_gap", abs_cyc - last_fs, FRAME);
            last_fs = abs_cyc;
            n_fs++;
        end
        if (ph == PIX_DIV - 1) held = source_colour(c);
    endtask

    // mode 0: random colour/test_sel, 1: constant ABC, 2: constant FFF
    task automatic run_cycles(input int unsigned n, input int mode);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            model_check();
            @(posedge clk);
            #1;
            k++;
            abs_cyc++;
            case (mode)
                1:       begin rgb_in = 12'hABC; test_sel = 1'b0; end
                2:       begin rgb_in = 12'hFFF; test_sel = 1'b0; end
                default: begin rgb_in = 12'($urandom); test_sel = 1'($urandom); end
            endcase
        end
    endtask

    initial begin
        int unsigned fs_before;
        logic        reached;
        rst      = 1'b1;
        rgb_in   = 12'hABC;
        test_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        k       = 0;
        last_fs = abs_cyc;

        run_cycles(H_TOTAL * PIX_DIV + 2 * PIX_DIV, 1);
        run_cycles(2 * FRAME, 0);
        run_cycles(FRAME, 2);

        // Walk to a mid-line, mid-frame point, then pulse reset for one clk.
        reached = 1'b0;
        for (int unsigned i = 0; i < 2 * FRAME && !reached; i++) begin
            if ((k / PIX_DIV) % H_TOTAL == 9 && (k / PIX_DIV) / H_TOTAL % V_TOTAL == 5 &&
                k % PIX_DIV == 1) begin
                reached = 1'b1;
            end else begin
                run_cycles(1, 0);
            end
        end
        check("reach_mid", 32'(reached), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
        rst = 1'b0;
        abs_cyc++;
        k       = 0;
        last_fs = abs_cyc;
        fs_before = n_fs;
        run_cycles(FRAME + 2 * PIX_DIV, 0);
        check("fs_after_rst", n_fs - fs_before, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_scan.md
# vga_scan

Raster scan controller for the VGA display path. It generates the `col`/`row` scan coordinates that the renderer consumes and samples the renderer's 12-bit `rgb_out` one pixel later. It emits registered, pixel-aligned `hs`/`vs`/`rgb` to the board pins. It also produces a per-frame strobe for game-state logic.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `PIX_DIV`, 4, clk cycles per pixel (≥2)
- `RGB_LAT`, 1, renderer latency in clk cycles from `col`/`row` to `rgb_in` (must be < `PIX_DIV`)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `rgb_in`  in  12  renderer colour {R4,G4,B4}
- `test_sel`  in  1  select colour-bar pattern (ignored unless macro set)
- `col`  out  10  current horizontal count, 0..H_TOTAL-1
- `row`  out  10  current vertical count, 0..V_TOTAL-1
- `pix_tick`  out  1  one-clk pulse at last clk of each pixel period
- `frame_start`  out  1  one-clk pulse when counters go to (0,0)
- `hs`  out  1  horizontal sync, active low
- `vs`  out  1  vertical sync, active low
- `rgb`  out  12  pixel colour to DAC; 0 in blanking

## Operation
- Widths: `H_TOTAL` = 800, `V_TOTAL` = 525 with default parameters; all counters 10-bit unsigned.
- Divider `div` counts 0..PIX_DIV-1 and wraps. `pix_tick` = (div == PIX_DIV-1).
- Coordinate advance on `pix_tick`:
  - `col` increments; at H_TOTAL-1 it wraps to 0 and `row` increments.
  - At row V_TOTAL-1 with a col wrap, `row` wraps to 0.
- Output stage updates only on `pix_tick`, using the pre-increment `col`/`row` and the `rgb_in` sampled that cycle:
  - `hs` = 0 iff col ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751].
  - `vs` = 0 iff row ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490,491].
  - `rgb` = (col<H_ACTIVE && row<V_ACTIVE) ? `rgb_in` : 12'h000.
- `frame_start` is asserted in the clk cycle after the `pix_tick` that wraps both counters.
- No handshake: the renderer must present valid `rgb_in` within RGB_LAT clks of each coordinate change.

## Timing
- Reset values: `div`=0, `col`=0, `row`=0, `pix_tick`=0, `frame_start`=0, `hs`=1, `vs`=1, `rgb`=0.
- First `pix_tick` occurs at clk PIX_DIV-1 after reset release.
- Pin latency: `hs`/`vs`/`rgb` for coordinate (c,r) appear exactly one pixel period after `col`=c/`row`=r first appears, and are held PIX_DIV clks.
- Frame period is H_TOTAL·V_TOTAL·PIX_DIV clks (1,680,000 by default). Line period is 3,200 clks.
- `rst` asserted mid-line: next clk all state returns to reset values and the scan restarts at (0,0) with no partial sync pulse.

## Configuration
- `VGA_SCAN_TESTPAT_EN` defined:
  - When `test_sel`=1, `rgb_in` is replaced with 8 vertical bars, each 80 px wide.
  - Bar colours in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Bar index is from a compare chain on `col`.
- Not defined: `test_sel` is ignored and `rgb` always follows `rgb_in`. No pattern logic is synthesised.

## Structure
- Shared package `vga_pkg`: default timing constants, derived `H_TOTAL`/`V_TOTAL`, sync-window bounds, colour typedef `rgb12_t`, test-bar colour constants.
- One sub-module, `scan_counter`: divider plus h/v counters, outputting `col`, `row`, `pix_tick` and the wrap flag.
- Sync decode, blanking and the output registers stay in `vga_scan`.

## Test plan
- Reset, then release: `hs`=`vs`=1, `rgb`=0, `col`=`row`=0. First `pix_tick` occurs at clk 3, after which `col`=1.
- Hold `rgb_in`=12'hABC for one full line: `rgb`=ABC for 640 pixels starting one pixel after col 0, then 0 for 160 pixels. `hs` is low for exactly 96 pixels, beginning one pixel after col 656.
- Run 2 frames: `frame_start` pulses are exactly 1,680,000 clks apart. `vs` is low for 2 lines (6,400 clks) beginning one pixel after (0,490).
- Set `rgb_in`=FFF and check rows 480..524: `rgb` stays 0 throughout vertical blanking.
- Assert `rst` at col 300, row 100 for one clk: all outputs return to reset values next clk. The next `frame_start` arrives 1,680,000 clks later.
- With `VGA_SCAN_TESTPAT_EN`, set `test_sel`=1 and `rgb_in`=0: pixels 0..79 → FFF, 80..159 → FF0, 560..639 → 000. Without the macro, `rgb` stays 0.
